// File: rtl/fetch_controller.sv
// fetch_controller
//   Sequences instruction fetch: owns the program counter, issues word-address
//   requests to instruction memory, hands fetched words to decode over a
//   valid/ready pair, and applies branch/jump redirects from decode.
//
// Ports
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   imem_req / imem_addr     outstanding fetch request and its word address
//   imem_ready / imem_rdata  memory response strobe and instruction word
//   inst_valid / inst_ready  decode handshake
//   inst / inst_pc           fetched instruction and its word address
//   redirect(_target)        one-cycle redirect pulse and new PC
//   fetch_count              instructions accepted by decode
//
// state | meaning
// IDLE  | post-reset cycle, no request outstanding
// FETCH | request to imem_addr outstanding, waiting for imem_ready
// HOLD  | instruction presented to decode, waiting for accept or redirect
module fetch_controller #(
  parameter int unsigned              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q,       state_d;
  logic [ADDR_W-1:0] pc_q,          pc_d;
  logic              inst_valid_q,  inst_valid_d;
  logic [31:0]       inst_q,        inst_d;
  logic [ADDR_W-1:0] inst_pc_q,     inst_pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              pend_q,        pend_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = redirect_target;
      end

      FETCH: begin
        if (!imem_ready) begin
          // The address must not move while the request is outstanding, so a
          // redirect is parked until the current response comes back.
          if (redirect) begin
            pend_d        = 1'b1;
            pend_target_d = redirect_target;
          end
        end else if (pend_q || redirect) begin
          // Response belongs to the wrong path: drop it and refetch.
          pc_d   = redirect ? redirect_target : pend_target_q;
          pend_d = 1'b0;
        end else begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          pc_d         = pc_q + PC_ONE;
          inst_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        // Redirect takes priority over acceptance: the held instruction is on
        // the wrong path and must not be counted.
        if (redirect) begin
          inst_valid_d = 1'b0;
          pc_d         = redirect_target;
          state_d      = FETCH;
        end else if (inst_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          inst_valid_d  = 1'b0;
          state_d       = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_valid_q  <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] fetch_count;

  int vectors     = 0;
  int miscompares = 0;
  int mem_lat     = 1;
  int wait_cnt    = 0;
  bit mem_auto    = 1'b1;

  fetch_controller #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // Memory model answers after mem_lat waiting cycles of an outstanding
  // request; redirect is a one-cycle pulse cleared after each edge.
  task automatic tick();
    if (mem_auto) begin
      if (imem_req) begin
        if (wait_cnt >= mem_lat) begin
          imem_ready = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ready = 1'b0;
        wait_cnt   = 0;
      end
    end
    @(posedge clock);
    #1;
    redirect = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = inst_valid;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = inst_valid;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    wait_cnt   = 0;
    mem_auto   = 1'b1;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({imem_req, inst_valid, inst, inst_pc, fetch_count, imem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b valid=%b inst=%h pc=%h cnt=%0d addr=%h expected all zero",
               imem_req, inst_valid, inst, inst_pc, fetch_count, imem_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    mem_lat = 1;
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== k) begin
        miscompares++;
        $display("FAIL seq_addr%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, k);
      end
      wait_valid(ok);
      vectors++;
      if (!ok || inst_pc !== k || inst !== mem_word(k)) begin
        miscompares++;
        $display("FAIL seq_inst%0d: got valid=%b pc=%h inst=%h expected pc=%h inst=%h",
                 k, inst_valid, inst_pc, inst, k, mem_word(k));
      end
      tick();
    end
    vectors++;
    if (fetch_count !== 32'd4) begin
      miscompares++;
      $display("FAIL seq_count: got %0d expected 4", fetch_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    mem_lat = 1;
    inst_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      tick();
    end
    inst_ready = 1'b0;
    wait_valid(ok);
    vectors++;
    if (!ok || inst_pc !== 32'd2) begin
      miscompares++;
      $display("FAIL bp_arrive: got valid=%b pc=%h expected valid=1 pc=2", inst_valid, inst_pc);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== mem_word(32'd2) || inst_pc !== 32'd2 ||
          imem_req !== 1'b0 || fetch_count !== 32'd2) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got valid=%b inst=%h pc=%h req=%b cnt=%0d expected 1 %h 2 0 2",
                 c, inst_valid, inst, inst_pc, imem_req, fetch_count, mem_word(32'd2));
      end
    end
    inst_ready = 1'b1;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd3 || fetch_count !== 32'd3) begin
      miscompares++;
      $display("FAIL bp_resume: got req=%b addr=%h cnt=%0d expected 1 3 3", imem_req, imem_addr, fetch_count);
    end
  endtask

  task automatic test_redirect_fetch();
    bit ok;
    wait_valid(ok);
    tick();
    mem_lat = 3;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin
      miscompares++;
      $display("FAIL rf_start: got req=%b addr=%h expected 1 4", imem_req, imem_addr);
    end
    redirect = 1'b1;
    redirect_target = 32'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (imem_addr !== 32'd4 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rf_stable%0d: got addr=%h req=%b valid=%b expected 4 1 0", c, imem_addr, imem_req, inst_valid);
      end
    end
    tick();
    vectors++;
    if (imem_addr !== 32'd9 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rf_discard: got addr=%h req=%b valid=%b expected 9 1 0", imem_addr, imem_req, inst_valid);
    end
    mem_lat = 1;
    wait_valid(ok);
    vectors++;
    if (!ok || inst_pc !== 32'd9 || inst !== mem_word(32'd9)) begin
      miscompares++;
      $display("FAIL rf_target: got valid=%b pc=%h inst=%h expected pc=9", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    redirect = 1'b1;
    redirect_target = 32'h20;
    inst_ready = 1'b1;
    tick();
    vectors++;
    if (fetch_count !== 32'd4 || inst_valid !== 1'b0 || imem_addr !== 32'h20 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rh_drop: got cnt=%0d valid=%b addr=%h req=%b expected 4 0 20 1",
               fetch_count, inst_valid, imem_addr, imem_req);
    end
    mem_lat = 3;
    redirect = 1'b1;
    redirect_target = 32'd5;
    tick();
    redirect = 1'b1;
    redirect_target = 32'd7;
    tick();
    vectors++;
    if (imem_addr !== 32'h20) begin
      miscompares++;
      $display("FAIL rh_pend_stable: got addr=%h expected 20", imem_addr);
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = (imem_addr !== 32'h20) || inst_valid;
    end
    vectors++;
    if (!ok || imem_addr !== 32'd7 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rh_last_wins: got addr=%h valid=%b expected 7 0", imem_addr, inst_valid);
    end
    mem_lat = 1;
    wait_valid(ok);
    vectors++;
    if (!ok || inst_pc !== 32'd7) begin
      miscompares++;
      $display("FAIL rh_target: got valid=%b pc=%h expected pc=7", inst_valid, inst_pc);
    end
    tick();
    vectors++;
    if (fetch_count !== 32'd5) begin
      miscompares++;
      $display("FAIL rh_count: got %0d expected 5", fetch_count);
    end
  endtask

  task automatic test_pc_wrap();
    bit ok;
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    tick();
    wait_valid(ok);
    vectors++;
    if (!ok || inst_pc !== 32'hFFFF_FFFF || inst !== mem_word(32'hFFFF_FFFF)) begin
      miscompares++;
      $display("FAIL wrap_inst: got valid=%b pc=%h inst=%h expected pc=ffffffff inst=%h",
               inst_valid, inst_pc, inst, mem_word(32'hFFFF_FFFF));
    end
    tick();
    vectors++;
    if (imem_addr !== 32'd0 || imem_req !== 1'b1 || fetch_count !== 32'd6) begin
      miscompares++;
      $display("FAIL wrap_next: got addr=%h req=%b cnt=%0d expected 0 1 6", imem_addr, imem_req, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    inst_ready = 1'b0;
    wait_valid(ok);
    vectors++;
    if (!ok || imem_addr !== 32'd1) begin
      miscompares++;
      $display("FAIL ar_pre_hold: got valid=%b addr=%h expected 1 1", inst_valid, imem_addr);
    end
    #2;
    reset = 1'b1;
    imem_ready = 1'b0;
    #1;
    vectors++;
    if ({imem_req, inst_valid, inst, inst_pc, fetch_count, imem_addr} !== '0) begin
      miscompares++;
      $display("FAIL ar_hold: got req=%b valid=%b inst=%h pc=%h cnt=%0d addr=%h expected all zero",
               imem_req, inst_valid, inst, inst_pc, fetch_count, imem_addr);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    wait_cnt = 0;
    redirect = 1'b1;
    redirect_target = 32'h33;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h33) begin
      miscompares++;
      $display("FAIL ar_idle_redirect: got req=%b addr=%h expected 1 33", imem_req, imem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_fetch: got req=%b addr=%h valid=%b expected 0 0 0", imem_req, imem_addr, inst_valid);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    wait_cnt = 0;
    mem_auto = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL ar_stray: got valid=%b req=%b addr=%h expected 0 1 0", inst_valid, imem_req, imem_addr);
    end
    mem_auto = 1'b1;
    mem_lat = 1;
    wait_valid(ok);
    vectors++;
    if (!ok || inst_pc !== 32'd0 || inst !== mem_word(32'd0)) begin
      miscompares++;
      $display("FAIL ar_restart: got valid=%b pc=%h inst=%h expected pc=0 inst=%h",
               inst_valid, inst_pc, inst, mem_word(32'd0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_fetch();
    test_redirect_hold();
    test_pc_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
